// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes and debounces four active-low keys into
// active-high levels plus one-cycle press pulses. Defining the macro
// BUTTON_CONDITIONER_AUTO_REPEAT_EN adds per-key auto-repeat pulses while a
// key is held (first repeat after REPEAT_DELAY, then every REPEAT_PERIOD).
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_n,
    output logic [3:0] key_level,
    output logic [3:0] key_event
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(RMAX);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RD_PRE  = RW'(REPEAT_DELAY - 2);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [RW-1:0] RP_PRE  = RW'(REPEAT_PERIOD - 2);
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
`endif

    logic [3:0] r_s1;
    logic [3:0] r_s2;

    // two-flop synchronizer; resets to the released (high) level
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= '1;
            r_s2 <= '1;
        end else begin
            r_s1 <= key_n;
            r_s2 <= r_s1;
        end
    end

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_key
            logic          r_db;
            logic [DW-1:0] r_dcnt;
            logic          r_event;
            logic          w_diff;
            logic          w_take;
            logic          w_rise;
            logic          w_fall;

            assign w_diff       = r_s2[k] != r_db;
            assign w_take       = w_diff && (r_dcnt == D_LAST);
            assign w_rise       = w_take && !r_s2[k];
            assign w_fall       = w_take && r_s2[k];
            assign key_level[k] = ~r_db;
            assign key_event[k] = r_event;

            // debounce: accept s2 only after it has differed for DEBOUNCE_CYCLES cycles
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_db   <= 1'b1;
                    r_dcnt <= '0;
                end else if (!w_diff) begin
                    r_dcnt <= '0;
                end else if (w_take) begin
                    r_db   <= r_s2[k];
                    r_dcnt <= '0;
                end else begin
                    r_dcnt <= r_dcnt + 1'b1;
                end
            end

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
            state_t        r_state;
            logic [RW-1:0] r_rcnt;

            // repeat FSM; pulses are registered one edge early so they land in the terminal-count cycle
            always_ff @(posedge clk) begin
                if (reset || w_fall) begin
                    r_state <= IDLE;
                    r_rcnt  <= '0;
                    r_event <= 1'b0;
                end else begin
                    case (r_state)
                        IDLE: begin
                            r_event <= w_rise;
                            r_rcnt  <= '0;
                            if (w_rise) r_state <= DELAY;
                        end
                        DELAY: begin
                            r_event <= r_rcnt == RD_PRE;
                            r_rcnt  <= (r_rcnt == RD_LAST) ? '0 : r_rcnt + 1'b1;
                            if (r_rcnt == RD_LAST) r_state <= REPEAT;
                        end
                        REPEAT: begin
                            r_event <= r_rcnt == RP_PRE;
                            r_rcnt  <= (r_rcnt == RP_LAST) ? '0 : r_rcnt + 1'b1;
                        end
                        default: begin
                            r_state <= IDLE;
                            r_rcnt  <= '0;
                            r_event <= 1'b0;
                        end
                    endcase
                end
            end
`else
            // press pulse coincides with the first cycle the level reads pressed
            always_ff @(posedge clk) begin
                r_event <= reset ? 1'b0 : w_rise;
            end
`endif
        end
    endgenerate
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed scenarios with a queue-based scoreboard for key events and spot checks
module tb_button_conditioner;
    typedef struct {
        int         cyc;
        logic [3:0] ev;
        logic [3:0] lvl;
    } exp_t;

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] key_n = 4'hF;
    logic [3:0] key_level;
    logic [3:0] key_event;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    bit         done = 1'b0;
    bit         fin = 1'b0;
    logic [3:0] prev_ev = 4'h0;
    exp_t       evq[$];
    exp_t       spq[$];

    button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_n(key_n),
        .key_level(key_level),
        .key_event(key_event)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: pops expected events when the DUT pulses, and due spot checks each cycle
    always @(negedge clk) begin
        exp_t e;
        if (key_event != 4'h0) begin
            checks++;
            if ((key_event & prev_ev) != 4'h0) begin
                failures++;
                $display("FAIL back_to_back cyc=%0d got ev=%b after ev=%b required no repeat", cyc, key_event, prev_ev);
            end
            checks++;
            if (evq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event cyc=%0d got ev=%b lvl=%b required none", cyc, key_event, key_level);
            end else begin
                e = evq.pop_front();
                if (cyc != e.cyc || key_event != e.ev || key_level != e.lvl) begin
                    failures++;
                    $display("FAIL event got cyc=%0d ev=%b lvl=%b required cyc=%0d ev=%b lvl=%b",
                             cyc, key_event, key_level, e.cyc, e.ev, e.lvl);
                end
            end
        end
        prev_ev = key_event;
        while (spq.size() != 0 && spq[0].cyc <= cyc) begin
            e = spq.pop_front();
            checks++;
            if (e.cyc != cyc || key_event != e.ev || key_level != e.lvl) begin
                failures++;
                $display("FAIL spot cyc=%0d got ev=%b lvl=%b required cyc=%0d ev=%b lvl=%b",
                         cyc, key_event, key_level, e.cyc, e.ev, e.lvl);
            end
        end
        if (done && !fin) begin
            checks++;
            if (evq.size() != 0) begin
                failures++;
                $display("FAIL missing_events got %0d pending required 0 (next cyc=%0d ev=%b)", evq.size(), evq[0].cyc, evq[0].ev);
            end
            checks++;
            if (spq.size() != 0) begin
                failures++;
                $display("FAIL missing_spots got %0d pending required 0", spq.size());
            end
            fin = 1'b1;
        end
    end

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int c, input logic [3:0] v);
        evq.push_back('{cyc: c, ev: v, lvl: v});
    endtask

    task automatic reps(input int c0, input logic [3:0] v, input int first, input int last, input int step);
        for (int t = first; t <= last; t += step)
            if (REP) push_ev(c0 + t, v);
    endtask

    task automatic spot(input int c, input logic [3:0] lvl);
        spq.push_back('{cyc: c, ev: 4'h0, lvl: lvl});
    endtask

    initial begin
        int c0;
        adv(1);
        spot(cyc, 4'h0);
        adv(2);
        spot(cyc, 4'h0);
        adv(1);
        reset = 1'b0;
        adv(3);

        c0 = cyc;
        key_n = 4'b1110;
        push_ev(c0 + 6, 4'b0001);
        spot(c0 + 10, 4'b0001);
        spot(c0 + 15, 4'b0000);
        adv(8);
        key_n = 4'hF;
        adv(20);

        c0 = cyc;
        key_n = 4'b1101;
        spot(c0 + 4, 4'b0000);
        spot(c0 + 7, 4'b0000);
        adv(3);
        key_n = 4'hF;
        adv(15);

        c0 = cyc;
        key_n = 4'b1011;
        push_ev(c0 + 6, 4'b0100);
        reps(c0, 4'b0100, 15, 30, 3);
        spot(c0 + 33, 4'b0000);
        adv(27);
        key_n = 4'hF;
        adv(15);

        c0 = cyc;
        key_n = 4'b0110;
        push_ev(c0 + 6, 4'b1001);
        reps(c0, 4'b1001, 15, 21, 3);
        spot(c0 + 22, 4'b0000);
        adv(16);
        key_n = 4'hF;
        adv(12);

        c0 = cyc;
        key_n = 4'b1101;
        push_ev(c0 + 6, 4'b0010);
        reps(c0, 4'b0010, 15, 18, 3);
        spot(c0 + 20, 4'b0000);
        spot(c0 + 21, 4'b0000);
        push_ev(c0 + 27, 4'b0010);
        reps(c0, 4'b0010, 36, 42, 3);
        spot(c0 + 43, 4'b0000);
        adv(19);
        reset = 1'b1;
        adv(2);
        reset = 1'b0;
        adv(16);
        key_n = 4'hF;
        adv(12);

        done = 1'b1;
        adv(3);
        if (!fin) begin
            $display("FAIL monitor_final got no final check required one");
            $fatal(1, "monitor did not complete");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
